ahb_read_ctrl: RTL and testbench

// - AHB-Lite slave-side controller that sequences the 8-bit register read datapath.
// - Accepts address phases, decodes a 4-entry register map and inserts programmable wait states.
// - Drives read_select/rd_en to the datapath one cycle before data is due, then signals completion.
// - Sits between the AHB decoder/mux and the read datapath; owns hreadyout and hresp for this slave.

---
 rtl/ahb_read_ctrl.sv | 157 +++++++++++++++
 tb/tb_ahb_read_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_read_ctrl.sv
// ----------------------------------------------------------------------------
// ahb_read_ctrl
// AHB-Lite slave-side controller for the 8-bit register read datapath.
// Decodes a 4-entry register map (status, payload0, payload1, size), stretches
// each read data phase by WAIT_STATES cycles, and pulses rd_en one cycle before
// the data is due so the datapath can capture the selected register.
//
// Optional feature macro: AHB_READ_CTRL_ERR_RESP_EN
//   defined   : writes and unmapped/misaligned/non-byte accesses receive a
//               two-cycle AHB ERROR response (ERR1, ERR2).
//   undefined : such accesses are ignored with a zero-wait OKAY, and the
//               ERR states are not built.
// ----------------------------------------------------------------------------
module ahb_read_ctrl #(
   parameter int ADDR_W      = 8,   // haddr width, must be >= 5
   parameter int WAIT_STATES = 1    // data-phase cycles with hreadyout=0, 1..15
) (
   input  logic              hclk,
   input  logic              hreset_n,
   input  logic              hsel,
   input  logic [1:0]        htrans,
   input  logic [ADDR_W-1:0] haddr,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic              hready,
   output logic              hreadyout,
   output logic              hresp,
   output logic [1:0]        read_select,
   output logic              rd_en
);

   // Counter load value: the counter runs WAIT_STATES-1 down to 0, so the
   // WAIT state lasts exactly WAIT_STATES cycles.
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

`ifdef AHB_READ_CTRL_ERR_RESP_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_LAST,
      ST_ERR1,
      ST_ERR2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_LAST
   } state_t;
`endif

   state_t     state_q, state_d;
   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic [1:0] read_select_q, read_select_d;

   logic       accept;     // an address phase is handed to this slave
   logic       map_ok;     // address/size hit a legal register slot
   logic       rd_ok;      // accepted, legal read
   logic       take_addr;  // current state is able to start a new transfer

   // An address phase is ours only when selected, active (NONSEQ/SEQ) and the
   // bus as a whole is ready; anything else leaves the state untouched.
   assign accept = hsel & htrans[1] & hready;

   // Only byte accesses to word-aligned slots 0x0, 0x4, 0x8, 0xC are mapped.
   assign map_ok = ((haddr >> 4) == '0) && (haddr[1:0] == 2'b00) && (hsize == 3'b000);

   assign rd_ok = accept & ~hwrite & map_ok;

`ifdef AHB_READ_CTRL_ERR_RESP_EN
   logic rd_bad;  // accepted, but a write or an illegal access
   assign rd_bad = accept & ~rd_ok;
`endif

   // State, wait counter and register index; async reset drops everything to IDLE.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q       <= ST_IDLE;
         wait_cnt_q    <= '0;
         read_select_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         read_select_q <= read_select_d;
      end
   end

   // Next-state and Moore outputs; outputs depend on state only so a reset
   // mid-transfer restores them at once.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      read_select_d = read_select_q;
      hreadyout     = 1'b1;
      hresp         = 1'b0;
      rd_en         = 1'b0;
      take_addr     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            take_addr = 1'b1;
         end

         ST_WAIT: begin
            hreadyout = 1'b0;
            if (wait_cnt_q == 4'd0) begin
               // Datapath captures now; hrdata is valid during LAST.
               rd_en   = 1'b1;
               state_d = ST_LAST;
            end else begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end
         end

         ST_LAST: begin
            // Transfer completes this cycle; a pipelined address phase may
            // start the next one without an IDLE bubble.
            take_addr = 1'b1;
         end

`ifdef AHB_READ_CTRL_ERR_RESP_EN
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = 1'b1;
            state_d   = ST_ERR2;
         end

         ST_ERR2: begin
            hresp     = 1'b1;
            take_addr = 1'b1;
         end
`endif

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Shared address-phase handling for every state that shows hreadyout=1.
      if (take_addr) begin
         state_d = ST_IDLE;
         if (rd_ok) begin
            state_d       = ST_WAIT;
            wait_cnt_d    = WAIT_INIT;
            read_select_d = haddr[3:2];
         end
`ifdef AHB_READ_CTRL_ERR_RESP_EN
         else if (rd_bad) begin
            state_d = ST_ERR1;
         end
`endif
      end
   end

   assign read_select = read_select_q;

endmodule

// File: tb/tb_ahb_read_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ahb_read_ctrl
// Two controllers (WAIT_STATES=1 and WAIT_STATES=3) share one AHB input bus.
// A transaction-level model predicts, for each controller, the remaining
// data-phase cycles of the transfer in flight and derives the outputs from it.
// Honours AHB_READ_CTRL_ERR_RESP_EN when the bench is built with it.
// ----------------------------------------------------------------------------
module tb_ahb_read_ctrl;

   localparam int ADDR_W = 8;
   localparam int WS_A   = 1;
   localparam int WS_B   = 3;
`ifdef AHB_READ_CTRL_ERR_RESP_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic              hclk = 1'b0;
   logic              hreset_n;
   logic              hsel;
   logic [1:0]        htrans;
   logic [ADDR_W-1:0] haddr;
   logic              hwrite;
   logic [2:0]        hsize;
   logic              hready;

   logic              ro [2];
   logic              rs [2];
   logic              en [2];
   logic [1:0]        sl [2];

   always #5 hclk = ~hclk;

   ahb_read_ctrl #(.ADDR_W(ADDR_W), .WAIT_STATES(WS_A)) u_dut_a (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .htrans(htrans),
      .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hready(hready),
      .hreadyout(ro[0]), .hresp(rs[0]), .read_select(sl[0]), .rd_en(en[0])
   );

   ahb_read_ctrl #(.ADDR_W(ADDR_W), .WAIT_STATES(WS_B)) u_dut_b (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .htrans(htrans),
      .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hready(hready),
      .hreadyout(ro[1]), .hresp(rs[1]), .read_select(sl[1]), .rd_en(en[1])
   );

   int checks = 0;
   int errors = 0;
   int pulses_b = 0;

   // Model: rem = data-phase cycles still to show for the transfer in flight
   // (0 = nothing in flight), kerr = that transfer is an ERROR response.
   int         rem  [2];
   bit         kerr [2];
   logic [1:0] msel [2];

   typedef struct {
      logic       s;
      logic [1:0] t;
      logic [7:0] a;
      logic       w;
      logic [2:0] z;
      logic       r;
      logic       e_ro;
      logic       e_rs;
      logic       e_en;
      logic [1:0] e_sel;
   } vec_t;

   vec_t tbl [25];

   function automatic int wsv(int d);
      return (d == 0) ? WS_A : WS_B;
   endfunction

   function automatic vec_t mk(logic s, logic [1:0] t, logic [7:0] a, logic w, logic [2:0] z,
                               logic r, logic e_ro, logic e_rs, logic e_en, logic [1:0] e_sel);
      vec_t v;
      v.s = s; v.t = t; v.a = a; v.w = w; v.z = z; v.r = r;
      v.e_ro = e_ro; v.e_rs = e_rs; v.e_en = e_en; v.e_sel = e_sel;
      return v;
   endfunction

   task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         rem[d]  = 0;
         kerr[d] = 1'b0;
         msel[d] = 2'd0;
      end
   endtask

   task automatic check_model();
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("hreadyout_%0d", d), 4'(ro[d]), 4'(rem[d] <= 1));
         chk($sformatf("hresp_%0d", d),     4'(rs[d]), 4'(kerr[d] && rem[d] > 0));
         chk($sformatf("rd_en_%0d", d),     4'(en[d]), 4'(!kerr[d] && rem[d] == 2));
         chk($sformatf("read_select_%0d", d), 4'(sl[d]), 4'(msel[d]));
      end
      if (en[1] === 1'b1) pulses_b++;
   endtask

   // Advance the model across one rising edge using the inputs that were on the bus.
   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         bit acc;
         bit ok;
         acc = hsel && htrans[1] && hready && (rem[d] <= 1);
         if (rem[d] > 0) rem[d]--;
         if (acc) begin
            ok = !hwrite && (hsize == 3'd0) && (haddr[7:4] == 4'd0) && (haddr[1:0] == 2'd0);
            if (ok) begin
               rem[d]  = wsv(d) + 1;
               kerr[d] = 1'b0;
               msel[d] = haddr[3:2];
            end else if (ERR) begin
               rem[d]  = 2;
               kerr[d] = 1'b1;
            end
         end
      end
   endtask

   task automatic drive(logic s, logic [1:0] t, logic [7:0] a, logic w, logic [2:0] z, logic r);
      hsel = s; htrans = t; haddr = a; hwrite = w; hsize = z; hready = r;
   endtask

   // One bus cycle: drive after the falling edge, check, cross the rising edge.
   task automatic cycle(logic s, logic [1:0] t, logic [7:0] a, logic w, logic [2:0] z, logic r);
      drive(s, t, a, w, z, r);
      #1;
      check_model();
      @(posedge hclk);
      model_edge();
      @(negedge hclk);
   endtask

   task automatic idle_cycles(int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 8'h00, 1'b0, 3'd0, 1'b1);
   endtask

   initial begin
      // Table for the WAIT_STATES=1 controller; outputs are those shown in
      // the cycle the row's address phase is on the bus.
      tbl[0]  = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  1, 0, 0, 2'd0);
      tbl[1]  = mk(1, 2'b10, 8'h04, 0, 3'd0, 1,  1, 0, 0, 2'd0);
      tbl[2]  = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  0, 0, 1, 2'd1);
      tbl[3]  = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  1, 0, 0, 2'd1);
      tbl[4]  = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  1, 0, 0, 2'd1);
      tbl[5]  = mk(1, 2'b01, 8'h08, 0, 3'd0, 1,  1, 0, 0, 2'd1);
      tbl[6]  = mk(0, 2'b10, 8'h08, 0, 3'd0, 1,  1, 0, 0, 2'd1);
      tbl[7]  = mk(1, 2'b10, 8'h08, 0, 3'd0, 0,  1, 0, 0, 2'd1);
      tbl[8]  = mk(1, 2'b10, 8'h0C, 0, 3'd0, 1,  1, 0, 0, 2'd1);
      tbl[9]  = mk(1, 2'b10, 8'h08, 0, 3'd0, 0,  0, 0, 1, 2'd3);
      tbl[10] = mk(1, 2'b10, 8'h08, 0, 3'd0, 1,  1, 0, 0, 2'd3);
      tbl[11] = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  0, 0, 1, 2'd2);
      tbl[12] = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  1, 0, 0, 2'd2);
      tbl[13] = mk(1, 2'b10, 8'h10, 0, 3'd0, 1,  1, 0, 0, 2'd2);
      tbl[14] = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  !ERR, ERR, 0, 2'd2);
      tbl[15] = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  1, ERR, 0, 2'd2);
      tbl[16] = mk(1, 2'b10, 8'h00, 1, 3'd0, 1,  1, 0, 0, 2'd2);
      tbl[17] = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  !ERR, ERR, 0, 2'd2);
      tbl[18] = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  1, ERR, 0, 2'd2);
      tbl[19] = mk(1, 2'b10, 8'h05, 0, 3'd0, 1,  1, 0, 0, 2'd2);
      tbl[20] = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  !ERR, ERR, 0, 2'd2);
      tbl[21] = mk(1, 2'b10, 8'h04, 0, 3'd1, 1,  1, ERR, 0, 2'd2);
      tbl[22] = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  !ERR, ERR, 0, 2'd2);
      tbl[23] = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  1, ERR, 0, 2'd2);
      tbl[24] = mk(0, 2'b00, 8'h00, 0, 3'd0, 1,  1, 0, 0, 2'd2);

      // Reset state
      drive(1'b0, 2'b00, 8'h00, 1'b0, 3'd0, 1'b1);
      hreset_n = 1'b0;
      model_reset();
      @(negedge hclk);
      @(negedge hclk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("rst_hreadyout_%0d", d), 4'(ro[d]), 4'd1);
         chk($sformatf("rst_hresp_%0d", d),     4'(rs[d]), 4'd0);
         chk($sformatf("rst_rd_en_%0d", d),     4'(en[d]), 4'd0);
         chk($sformatf("rst_read_select_%0d", d), 4'(sl[d]), 4'd0);
      end
      @(negedge hclk);
      hreset_n = 1'b1;
      idle_cycles(2);

      // Table-driven vectors
      for (int i = 0; i < 25; i++) begin
         drive(tbl[i].s, tbl[i].t, tbl[i].a, tbl[i].w, tbl[i].z, tbl[i].r);
         #1;
         chk($sformatf("tbl%0d_hreadyout", i), 4'(ro[0]), 4'(tbl[i].e_ro));
         chk($sformatf("tbl%0d_hresp", i),     4'(rs[0]), 4'(tbl[i].e_rs));
         chk($sformatf("tbl%0d_rd_en", i),     4'(en[0]), 4'(tbl[i].e_en));
         chk($sformatf("tbl%0d_read_select", i), 4'(sl[0]), 4'(tbl[i].e_sel));
         check_model();
         @(posedge hclk);
         model_edge();
         @(negedge hclk);
      end
      idle_cycles(6);

      // Back-to-back reads 0x08 then 0x0C on the WAIT_STATES=3 controller;
      // the second address phase is held until that controller reaches LAST.
      pulses_b = 0;
      cycle(1'b1, 2'b10, 8'h08, 1'b0, 3'd0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'b10, 8'h0C, 1'b0, 3'd0, 1'b1);
      idle_cycles(6);
      chk("b2b_rd_en_pulses", 4'(pulses_b), 4'd2);
      chk("b2b_final_select", 4'(sl[1]), 4'd3);

      // Asynchronous reset in the middle of a WAIT phase
      cycle(1'b1, 2'b10, 8'h04, 1'b0, 3'd0, 1'b1);
      idle_cycles(1);
      #2;
      hreset_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("midrst_hreadyout_%0d", d), 4'(ro[d]), 4'd1);
         chk($sformatf("midrst_rd_en_%0d", d),     4'(en[d]), 4'd0);
         chk($sformatf("midrst_hresp_%0d", d),     4'(rs[d]), 4'd0);
         chk($sformatf("midrst_read_select_%0d", d), 4'(sl[d]), 4'd0);
      end
      model_reset();
      @(negedge hclk);
      hreset_n = 1'b1;
      pulses_b = 0;
      idle_cycles(6);
      chk("midrst_no_late_rd_en", 4'(pulses_b), 4'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic       s;
         logic [1:0] t;
         logic [7:0] a;
         logic       w;
         logic [2:0] z;
         logic       r;
         s = ($urandom_range(0, 3) != 0);
         t = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) a = 8'($urandom);
         else                           a = {4'h0, 2'($urandom_range(0, 3)), 2'b00};
         w = ($urandom_range(0, 7) == 0);
         z = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
         r = ($urandom_range(0, 3) != 0);
         cycle(s, t, a, w, z, r);
      end
      idle_cycles(6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
